// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming distance sequencer.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold the value n, i.e. floor(log2 n)+1.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((n >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_slice_sreg.sv
// Loadable right-shift register presenting its low M bits as a slice.
module hamming_slice_sreg #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic [M-1:0] slice
);

  logic [N-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q >> M;
    end
  end

  assign slice = q[M-1:0];

endmodule

// File: rtl/hamming_seq_ctrl.sv
// Streams an operand pair to the multi-cycle Hamming core in M-bit slices
// and captures the final distance behind a valid/ready output.
module hamming_seq_ctrl
  import hamming_pkg::*;
#(
  parameter  int N  = 1600,
  parameter  int CC = 1,
  localparam int M  = N / CC,
  localparam int W  = log2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  output logic [M-1:0] x_slice,
  output logic [M-1:0] y_slice,
  output logic         acc_clr,
  input  logic [W-1:0] dist_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dist_out
);

  localparam int CW = (CC > 1) ? $clog2(CC) : 1;

  if (N % CC != 0) begin : g_bad_cc
    $error("hamming_seq_ctrl: N must be a multiple of CC");
  end

  state_t          state;
  logic   [CW-1:0] cnt;
  logic   [M-1:0]  xs;
  logic   [M-1:0]  ys;
  logic            load;
  logic            shift;

  assign in_ready = (state == IDLE);
  assign acc_clr  = (state != RUN);
  assign load     = in_ready && in_valid;
  assign shift    = (state == RUN);
  assign x_slice  = shift ? xs : '0;
  assign y_slice  = shift ? ys : '0;

  hamming_slice_sreg #(.N(N), .M(M)) u_x (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (x_in),
    .slice (xs)
  );

  hamming_slice_sreg #(.N(N), .M(M)) u_y (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (y_in),
    .slice (ys)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dist_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // dist_in already includes the last slice on this cycle
          if (cnt == CW'(CC - 1)) begin
            dist_out  <= dist_in;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Scoreboard bench: two sequencers (CC=4, CC=1) each driving a core model.
module tb_hamming_seq_ctrl;

  localparam int N = 16;
  localparam int W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // CC=4 instance signals
  logic          rst4, iv4, ir4, clr4, ov4, or4;
  logic [N-1:0]  x4, y4;
  logic [3:0]    xs4, ys4;
  logic [W-1:0]  din4, do4, acc4;
  // CC=1 instance signals
  logic          rst1, iv1, ir1, clr1, ov1, or1;
  logic [N-1:0]  x1, y1;
  logic [N-1:0]  xs1, ys1;
  logic [W-1:0]  din1, do1, acc1;

  hamming_seq_ctrl #(.N(N), .CC(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4),
    .x_in(x4), .y_in(y4), .x_slice(xs4), .y_slice(ys4),
    .acc_clr(clr4), .dist_in(din4), .out_valid(ov4),
    .out_ready(or4), .dist_out(do4)
  );

  hamming_seq_ctrl #(.N(N), .CC(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1),
    .x_in(x1), .y_in(y1), .x_slice(xs1), .y_slice(ys1),
    .acc_clr(clr1), .dist_in(din1), .out_valid(ov1),
    .out_ready(or1), .dist_out(do1)
  );

  // Core models: running distance including the current slice
  assign din4 = acc4 + W'($countones(xs4 ^ ys4));
  assign din1 = acc1 + W'($countones(xs1 ^ ys1));
  always @(posedge clk) acc4 <= clr4 ? '0 : din4;
  always @(posedge clk) acc1 <= clr1 ? '0 : din1;

  logic [W-1:0] q4[$];
  logic [W-1:0] q1[$];
  logic [3:0]   sl4[$];
  bit           grab4 = 0;
  int           low4 = 0;
  int           low1 = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ov4 && or4) begin
      if (q4.size() == 0) chk("dist4_unexpected", 1, 0);
      else chk("dist4", 32'(do4), 32'(q4.pop_front()));
    end
    if (ov1 && or1) begin
      if (q1.size() == 0) chk("dist1_unexpected", 1, 0);
      else chk("dist1", 32'(do1), 32'(q1.pop_front()));
    end
    if (!clr4) low4++;
    if (!clr1) low1++;
    if (grab4 && !clr4) sl4.push_back(xs4);
  end

  task automatic drive(input bit s, input logic v,
                       input logic [N-1:0] x, input logic [N-1:0] y);
    if (s) begin
      iv1 = v; x1 = x; y1 = y;
    end else begin
      iv4 = v; x4 = x; y4 = y;
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? ir1 : ir4;
  endfunction

  task automatic send(input bit s, input logic [N-1:0] x,
                      input logic [N-1:0] y, input logic [W-1:0] e,
                      input bit push, output int t);
    int n;
    @(negedge clk);
    drive(s, 1'b1, x, y);
    n = 0;
    while (!rdy(s) && n < 100) begin
      @(negedge clk);
      n++;
    end
    t = -1;
    if (!rdy(s)) begin
      chk("accept_timeout", 0, 1);
    end else begin
      if (push) begin
        if (s) q1.push_back(e);
        else q4.push_back(e);
      end
      @(posedge clk);
      t = int'($time / 10);
    end
    #1 drive(s, 1'b0, x, y);
  endtask

  task automatic set_or(input bit s, input logic v);
    @(posedge clk);
    #1;
    if (s) or1 = v;
    else or4 = v;
  endtask

  initial begin
    int t, tp, n, bad, badr;
    logic [N-1:0] rx, ry;
    logic [15:0] sv;
    rst4 = 1; rst1 = 1; or4 = 0; or1 = 0;
    drive(0, 0, '0, '0);
    drive(1, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst4 = 0; rst1 = 0;
    @(negedge clk);
    chk("rst_in_ready", ir4, 1);
    chk("rst_acc_clr", clr4, 1);
    chk("rst_out_valid", ov4, 0);
    chk("rst_dist_out", do4, 0);
    chk("rst_slices", {xs4, ys4}, 0);
    chk("rst_in_ready1", ir1, 1);

    // 1: all bits differ, check out_valid latency
    send(0, 16'hFFFF, 16'h0000, 5'd16, 1, t);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov4 && n < 50);
    chk("ov_latency_cycles", n, 5);
    set_or(0, 1);
    set_or(0, 0);

    // 2: equal operands, slices LSB first
    or4 = 1;
    sl4.delete();
    grab4 = 1;
    send(0, 16'hA5A5, 16'hA5A5, 5'd0, 1, t);
    repeat (8) @(negedge clk);
    grab4 = 0;
    chk("slice_count", sl4.size(), 4);
    sv = '0;
    foreach (sl4[i]) sv = {sv[11:0], sl4[i]};
    chk("slice_order", sv, 16'h5A5A);

    // 3: single-slice build
    or1 = 1;
    repeat (2) @(negedge clk);
    low1 = 0;
    send(1, 16'h000F, 16'h00F0, 5'd8, 1, t);
    repeat (5) @(negedge clk);
    chk("clr_low_cycles1", low1, 1);

    // 4: stall in DONE with a competing input
    set_or(0, 0);
    send(0, 16'h1234, 16'h1235, 5'd1, 1, t);
    n = 0;
    while (!ov4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", ov4, 1);
    drive(0, 1, 16'hFFFF, 16'h0000);
    low4 = 0; bad = 0; badr = 0;
    repeat (10) begin
      @(negedge clk);
      if (do4 !== 5'd1 || ov4 !== 1'b1) bad++;
      if (ir4 !== 1'b0) badr++;
    end
    chk("hold_dist_stable", bad, 0);
    chk("hold_in_ready_low", badr, 0);
    drive(0, 0, '0, '0);
    set_or(0, 1);
    repeat (4) @(negedge clk);
    chk("no_accept_in_done", low4, 0);

    // 5: reset during RUN discards the result
    send(0, 16'hFFFF, 16'h0000, 5'd16, 0, t);
    @(posedge clk);
    #1 rst4 = 1;
    @(posedge clk);
    #1 rst4 = 0;
    @(negedge clk);
    chk("midrst_out_valid", ov4, 0);
    chk("midrst_in_ready", ir4, 1);
    chk("midrst_acc_clr", clr4, 1);
    send(0, 16'h0001, 16'h0000, 5'd1, 1, t);

    // 6: back-to-back throughput
    bad = 0; tp = -1;
    for (int i = 0; i < 100; i++) begin
      rx = N'($urandom);
      ry = N'($urandom);
      send(0, rx, ry, W'($countones(rx ^ ry)), 1, t);
      if (tp >= 0 && t - tp != 6) bad++;
      tp = t;
    end
    chk("spacing_cc4", bad, 0);
    bad = 0; tp = -1;
    for (int i = 0; i < 20; i++) begin
      rx = N'($urandom);
      ry = N'($urandom);
      send(1, rx, ry, W'($countones(rx ^ ry)), 1, t);
      if (tp >= 0 && t - tp != 3) bad++;
      tp = t;
    end
    chk("spacing_cc1", bad, 0);

    n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain4", q4.size(), 0);
    chk("sb_drain1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
